option_fifo: RTL and testbench

- Circular option store that feeds the line solver.
- Holds every candidate line option as a 16-bit word: the parser's initial enumeration first, then the options the solver recirculates via its put-back path.
- Presents the head option show-ahead, so the solver consumes one option per cycle.
- Raises `started` once the initial load completes, and flushes when the solver reports `solved`.

---
 rtl/option_fifo.sv | 125 ++++++++++++
 tb/tb_option_fifo.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/option_fifo.sv
// option_fifo: circular store of line options between the parser and the line solver.
// Head entry is presented show-ahead; the solver recirculates survivors through push.
module option_fifo #(
  parameter int MAX_ROWS        = 11,
  parameter int MAX_COLS        = 11,
  parameter int MAX_NUM_OPTIONS = 84,
  parameter int DEPTH           = (MAX_ROWS + MAX_COLS) * MAX_NUM_OPTIONS,
  parameter int WIDTH           = 16,
  localparam int PTR_W          = $clog2(DEPTH),
  localparam int CNT_W          = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             load_ready,
  output logic             started,
  output logic [WIDTH-1:0] option,
  output logic             option_valid,
  input  logic             pop,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             solved,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  // state | meaning
  // IDLE  | flushed or fresh; waiting for the parser's first word
  // LOAD  | initial enumeration in progress
  // RUN   | solver consumes and recirculates options; started = 1
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  state_e           state_q;
  logic             started_q;
  logic             overflow_q, underflow_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             run, load_acc, pop_acc, push_acc, ovf_evt, udf_evt, wr_en;
  logic [WIDTH-1:0] wr_data;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  assign run   = (state_q == S_RUN);

  always_comb begin
    load_ready = !run && !full;
    load_acc   = load_valid && load_ready && !solved;
    pop_acc    = run && pop && !empty && !solved;
    // a pop frees the slot this cycle, so push-while-full is fine when paired with pop
    push_acc   = run && push && (!full || pop) && !solved;
    ovf_evt    = run && push && full && !pop && !solved;
    udf_evt    = run && pop && empty && !solved;
    wr_en      = load_acc || push_acc;
    wr_data    = run ? push_data : load_data;

    wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
    rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;

    count_d = count_q;
    if (wr_en && !pop_acc)      count_d = count_q + 1'b1;
    else if (!wr_en && pop_acc) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      started_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q | ovf_evt;
      underflow_q <= underflow_q | udf_evt;
      if (solved) begin
        state_q   <= S_IDLE;
        started_q <= 1'b0;
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        count_q   <= '0;
      end else begin
        if (wr_en)   wr_ptr_q <= wr_ptr_d;
        if (pop_acc) rd_ptr_q <= rd_ptr_d;
        count_q <= count_d;
        case (state_q)
          S_IDLE, S_LOAD: begin
            if (load_acc) begin
              state_q   <= load_last ? S_RUN : S_LOAD;
              started_q <= load_last;
            end
          end
          S_RUN: ;
          default: begin
            state_q   <= S_IDLE;
            started_q <= 1'b0;
          end
        endcase
      end
    end
  end

  // storage is deliberately left uncleared by reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wr_data;
  end

  assign option       = mem_q[rd_ptr_q];
  assign option_valid = !empty;
  assign started      = started_q;
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_option_fifo.sv
// Scoreboard bench for option_fifo at DEPTH=8: a queue-based reference model predicts
// the post-edge outputs; a negedge monitor pops and compares each prediction.
module tb_option_fifo;
  localparam int DEPTH = 8;
  localparam int W     = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_valid = 1'b0, load_last = 1'b0, pop = 1'b0, push = 1'b0, solved = 1'b0;
  logic [W-1:0]  load_data = '0, push_data = '0;
  logic          load_ready, started, option_valid, full, empty, overflow, underflow;
  logic [W-1:0]  option;
  logic [CW-1:0] count;

  option_fifo #(.MAX_ROWS(2), .MAX_COLS(2), .MAX_NUM_OPTIONS(2), .DEPTH(DEPTH), .WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .started(started), .option(option), .option_valid(option_valid),
    .pop(pop), .push(push), .push_data(push_data), .solved(solved),
    .count(count), .full(full), .empty(empty), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] opt;
    int           cnt;
    bit           st, lr, of, uf;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] mq[$];
  bit           m_run = 0, m_of = 0, m_uf = 0;
  int           errors = 0, checks = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, queue the prediction after the edge.
  task automatic step(bit lv, logic [W-1:0] ld, bit ll, bit pp, bit ph, logic [W-1:0] pd, bit sv);
    exp_t e;
    bit   mfull, mempty;
    load_valid = lv; load_data = ld; load_last = ll;
    pop = pp; push = ph; push_data = pd; solved = sv;
    mfull  = (mq.size() == DEPTH);
    mempty = (mq.size() == 0);
    if (sv) begin
      mq.delete();
      m_run = 0;
    end else if (!m_run) begin
      if (lv && !mfull) begin
        mq.push_back(ld);
        if (ll) m_run = 1;
      end
    end else begin
      if (pp && mempty) m_uf = 1;
      if (ph && mfull && !pp) m_of = 1;
      if (pp && !mempty) void'(mq.pop_front());
      if (ph && (!mfull || pp)) mq.push_back(pd);
    end
    e.opt = (mq.size() > 0) ? mq[0] : '0;
    e.cnt = mq.size();
    e.st  = m_run;
    e.lr  = !m_run && (mq.size() < DEPTH);
    e.of  = m_of;
    e.uf  = m_uf;
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("count", int'(count), e.cnt);
      chk("started", int'(started), int'(e.st));
      chk("load_ready", int'(load_ready), int'(e.lr));
      chk("full", int'(full), int'(e.cnt == DEPTH));
      chk("empty", int'(empty), int'(e.cnt == 0));
      chk("option_valid", int'(option_valid), int'(e.cnt != 0));
      chk("overflow", int'(overflow), int'(e.of));
      chk("underflow", int'(underflow), int'(e.uf));
      if (e.cnt > 0) chk("option", int'(option), int'(e.opt));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_started", int'(started), 0);
    chk("rst_load_ready", int'(load_ready), 1);
    chk("rst_flags", int'({overflow, underflow}), 0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // initial load; started follows the third accept
    step(1, 16'h0003, 0, 0, 0, '0, 0);
    step(1, 16'h0005, 0, 0, 0, '0, 0);
    step(1, 16'h0006, 1, 0, 0, '0, 0);

    // recirculate the head six times; pointers wrap past index 7
    for (int i = 0; i < 6; i++) step(0, '0, 0, 1, 1, mq[0], 0);

    step(0, '0, 0, 0, 0, '0, 1);

    // fill to DEPTH, then a ninth offered word must be refused
    for (int i = 0; i < DEPTH; i++) step(1, 16'h0100 + 16'(i), i == DEPTH - 1, 0, 0, '0, 0);
    step(1, 16'h0999, 1, 0, 0, '0, 0);
    step(0, '0, 0, 0, 1, 16'h0BAD, 0);
    step(0, '0, 0, 1, 1, 16'h0ABC, 0);
    for (int i = 0; i < DEPTH; i++) step(0, '0, 0, 1, 0, '0, 0);

    // pop on empty with a simultaneous push
    step(0, '0, 0, 1, 1, 16'h00AA, 0);
    step(0, '0, 0, 1, 0, '0, 0);

    // solved with a push in the same cycle, then a fresh load
    step(0, '0, 0, 0, 1, 16'h1111, 0);
    step(0, '0, 0, 0, 1, 16'h2222, 0);
    step(0, '0, 0, 0, 1, 16'h3333, 1);
    step(1, 16'h0077, 0, 0, 0, '0, 0);
    step(1, 16'h0078, 1, 0, 0, '0, 0);

    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 2) != 0, 16'($urandom), $urandom_range(0, 5) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, 16'($urandom),
           $urandom_range(0, 39) == 0);
    end

    // asynchronous reset in the middle of a load with four words stored
    step(0, '0, 0, 0, 0, '0, 1);
    for (int i = 0; i < 4; i++) step(1, 16'h0400 + 16'(i), 0, 0, 0, '0, 0);
    load_valid = 0;
    for (int k = 0; k < 4 && exp_q.size() > 0; k++) begin
      @(negedge clk); #1;
    end
    chk("drain_before_reset", exp_q.size(), 0);
    chk("pre_reset_count", int'(count), 4);
    #1 rst = 1'b0;
    #1;
    chk("async_count", int'(count), 0);
    chk("async_empty", int'(empty), 1);
    chk("async_started", int'(started), 0);
    chk("async_load_ready", int'(load_ready), 1);
    chk("async_flags", int'({overflow, underflow}), 0);
    mq.delete(); m_run = 0; m_of = 0; m_uf = 0;
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("post_reset_load_ready", int'(load_ready), 1);
    chk("post_reset_count", int'(count), 0);
    step(1, 16'h0501, 0, 0, 0, '0, 0);
    step(1, 16'h0502, 1, 0, 0, '0, 0);
    step(0, '0, 0, 1, 0, '0, 0);
    step(0, '0, 0, 0, 0, '0, 0);
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
